// File: rtl/con3_pkg.sv
// Shared constants and sizing helpers for the multi-channel servo PWM generator.
package con3_pkg;

   localparam int ANGLE_W_DEF = 8;

   function automatic int frame_subs(input int high_cycle, input int low_cycle);
      return high_cycle + low_cycle + 1;
   endfunction

   // Width of a counter running 0 .. n-1, never less than one bit.
   function automatic int cnt_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/con3_multi_if.sv
// Control-side bundle of the servo generator: enables, angles, update strobe and status/PWM outputs.
interface con3_multi_if
   import con3_pkg::*;
#(
   parameter int CHANNELS = 4,
   parameter int ANGLE_W  = ANGLE_W_DEF
);
   logic [CHANNELS-1:0]         en;
   logic [CHANNELS*ANGLE_W-1:0] angle;
   logic                        update;
   logic                        pending;
   logic                        frame_start;
   logic [CHANNELS-1:0]         servo;

   modport master (
      output en, angle, update,
      input  pending, frame_start, servo
   );

   modport slave (
      input  en, angle, update,
      output pending, frame_start, servo
   );
endinterface

// File: rtl/con3_channel.sv
// One servo channel: shadow/target/active angle registers, optional slew limit and the PWM comparator.
module con3_channel
   import con3_pkg::*;
#(
   parameter int ANGLE_W   = ANGLE_W_DEF,
   parameter int SLEW_STEP = 0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic [ANGLE_W-1:0] angle,
   input  logic               update,
   input  logic               boundary,
   input  logic               apply,
   input  logic               in_high,
   input  logic               in_cmp,
   input  logic [ANGLE_W-1:0] tick,
   output logic               servo
);
   localparam int AW1       = ANGLE_W + 1;
   localparam int ANGLE_MAX = (2 ** ANGLE_W) - 1;
   localparam int STEP_SAT  = (SLEW_STEP > ANGLE_MAX) ? ANGLE_MAX : SLEW_STEP;
   localparam logic [AW1-1:0]     STEP_X = AW1'(STEP_SAT);
   localparam logic [ANGLE_W-1:0] STEP_N = ANGLE_W'(STEP_SAT);

   logic [ANGLE_W-1:0] shadow_q, shadow_d;
   logic [ANGLE_W-1:0] target_q, target_d;
   logic [ANGLE_W-1:0] active_q, active_d;
   logic               armed_q, armed_d;
   logic               servo_q, servo_d;
   logic [AW1-1:0]     goal_x, act_x;
   logic [ANGLE_W-1:0] slew_nxt;

   always_comb begin
      shadow_d = update ? angle : shadow_q;
      target_d = apply ? shadow_q : target_q;

      // One extra bit keeps the distance unsigned; the step is only taken when it cannot overshoot.
      goal_x   = {1'b0, target_d};
      act_x    = {1'b0, active_q};
      slew_nxt = target_d;
      if (SLEW_STEP != 0) begin
         if (goal_x > act_x) begin
            if ((goal_x - act_x) > STEP_X) slew_nxt = active_q + STEP_N;
         end else if ((act_x - goal_x) > STEP_X) begin
            slew_nxt = active_q - STEP_N;
         end
      end
      active_d = boundary ? slew_nxt : active_q;

      // A channel enabled mid-frame waits for the next frame start so no partial pulse escapes.
      if (!en)           armed_d = 1'b0;
      else if (boundary) armed_d = 1'b1;
      else               armed_d = armed_q;

      servo_d = en && (armed_q || boundary) && (in_high || (in_cmp && (tick < active_d)));
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         shadow_q <= '0;
         target_q <= '0;
         active_q <= '0;
         armed_q  <= 1'b0;
         servo_q  <= 1'b0;
      end else begin
         shadow_q <= shadow_d;
         target_q <= target_d;
         active_q <= active_d;
         armed_q  <= armed_d;
         servo_q  <= servo_d;
      end
   end

   assign servo = servo_q;

endmodule

// File: rtl/con3_multi.sv
// Multi-channel servo PWM generator: shared prescaler/tick/sub-frame timebase driving CHANNELS outputs.
module con3_multi
   import con3_pkg::*;
#(
   parameter int CHANNELS   = 4,
   parameter int ANGLE_W    = ANGLE_W_DEF,
   parameter int TICK_DIV   = 391,
   parameter int HIGH_CYCLE = 1,
   parameter int LOW_CYCLE  = 2,
   parameter int SLEW_STEP  = 0
) (
   input logic         clk,
   input logic         rst,
   con3_multi_if.slave bus
);
   localparam int SUBS = frame_subs(HIGH_CYCLE, LOW_CYCLE);
   localparam int PW   = cnt_w(TICK_DIV);
   localparam int SW   = cnt_w(SUBS);
   localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
   localparam logic [SW-1:0] SUB_LAST   = SW'(SUBS - 1);
   localparam logic [SW-1:0] SUB_HIGH   = SW'(HIGH_CYCLE);

   logic [PW-1:0]       presc_q, presc_d;
   logic [ANGLE_W-1:0]  tick_q, tick_d;
   logic [SW-1:0]       sub_q, sub_d;
   logic                pending_q, pending_d;
   logic                frame_start_q, frame_start_d;
   logic                step_tick, boundary, apply, in_high, in_cmp;
   logic [CHANNELS-1:0] servo_w;

   always_comb begin
      step_tick = (presc_q == PRESC_LAST);
      // All-zero counters mark the first clk of a frame, including straight out of reset.
      boundary  = (presc_q == '0) && (tick_q == '0) && (sub_q == '0);
      apply     = boundary && pending_q;
      in_high   = (sub_q < SUB_HIGH);
      in_cmp    = (sub_q == SUB_HIGH);

      presc_d = step_tick ? '0 : presc_q + PW'(1);
      tick_d  = tick_q;
      sub_d   = sub_q;
      if (step_tick) begin
         tick_d = tick_q + ANGLE_W'(1);
         if (tick_q == '1) sub_d = (sub_q == SUB_LAST) ? '0 : sub_q + SW'(1);
      end

      frame_start_d = boundary;
      // A strobe landing on the boundary is captured after the old shadow is applied.
      pending_d = bus.update ? 1'b1 : (boundary ? 1'b0 : pending_q);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         presc_q       <= '0;
         tick_q        <= '0;
         sub_q         <= '0;
         pending_q     <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         presc_q       <= presc_d;
         tick_q        <= tick_d;
         sub_q         <= sub_d;
         pending_q     <= pending_d;
         frame_start_q <= frame_start_d;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
         con3_channel #(
            .ANGLE_W   (ANGLE_W),
            .SLEW_STEP (SLEW_STEP)
         ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .en       (bus.en[gi]),
            .angle    (bus.angle[gi*ANGLE_W +: ANGLE_W]),
            .update   (bus.update),
            .boundary (boundary),
            .apply    (apply),
            .in_high  (in_high),
            .in_cmp   (in_cmp),
            .tick     (tick_q),
            .servo    (servo_w[gi])
         );
      end
   endgenerate

   assign bus.servo       = servo_w;
   assign bus.pending     = pending_q;
   assign bus.frame_start = frame_start_q;

endmodule
